// File: rtl/addrc_ctrl.sv
// Add-round-constant sequencer: per slice READ->LOAD->XOR->WRITE over 64 slices x NUM_ROUNDS rounds.
// Latency 2+256*NUM_ROUNDS cycles start-to-done; memory backpressure stretches READ until mem_ack.
module addrc_ctrl #(
  parameter int NUM_ROUNDS = 24,
  parameter int ROUND_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cnt_co_64,
  input  logic [5:0]         cnt_value,
  input  logic               mem_ack,
  output logic               cnt_en_64,
  output logic               cnt_rst_64,
  output logic               inreg_en,
  output logic               xor_en,
  output logic               mem_req,
  output logic               mem_wr,
  output logic [5:0]         mem_addr,
  output logic [ROUND_W-1:0] round_idx,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_READ,
    S_LOAD,
    S_XOR,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

  state_t state;
  state_t state_nxt;
  logic   last_round;

  assign last_round = (round_idx == LAST_ROUND);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Round index only advances on the slice-63 write; it holds after DONE until the next INIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      round_idx <= '0;
    end else if (state == S_INIT) begin
      round_idx <= '0;
    end else if (state == S_WRITE && cnt_co_64 && !last_round) begin
      round_idx <= round_idx + ROUND_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_INIT;
      S_INIT:  state_nxt = S_READ;
      S_READ:  if (mem_ack) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_XOR;
      S_XOR:   state_nxt = S_WRITE;
      S_WRITE: begin
        if (cnt_co_64 && last_round) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_READ;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_en_64  = 1'b0;
    cnt_rst_64 = 1'b0;
    inreg_en   = 1'b0;
    xor_en     = 1'b0;
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE:  busy = 1'b0;
      S_INIT:  cnt_rst_64 = 1'b1;
      S_READ:  mem_req = 1'b1;
      S_LOAD:  inreg_en = 1'b1;
      S_XOR:   xor_en = 1'b1;
      S_WRITE: begin
        mem_wr    = 1'b1;
        cnt_en_64 = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Address follows the datapath counter, but is quiet when memory is not being accessed.
  assign mem_addr = (mem_req || mem_wr) ? cnt_value : 6'd0;

endmodule

// File: doc/addrc_ctrl.md
Name: addrc_ctrl

Overview:
- Sequencing FSM for the add-round-constant (iota) datapath.
- Walks all 64 slice lines of the 64x25-bit state memory per round, for NUM_ROUNDS rounds.
- Per slice, in order: read memory, load the input register, pulse the xor enable, write back, advance the 64-counter.
- Exposes start/done/busy to the top-level round controller and a mem_req/mem_ack handshake to the state memory.

Parameters:
- NUM_ROUNDS, 24, number of rounds per start (1..31).
- ROUND_W, 5, width of round_idx; must satisfy 2^ROUND_W >= NUM_ROUNDS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request an operation; sampled only in IDLE.
- cnt_co_64  in  1  datapath 64-counter carry-out; high when the count is 63.
- cnt_value  in  6  datapath 64-counter value (current slice).
- mem_ack  in  1  memory read data valid on mem_line this cycle.
- cnt_en_64  out  1  increment the 64-counter.
- cnt_rst_64  out  1  reset the 64-counter to 0.
- inreg_en  out  1  capture mem_line into the slice register.
- xor_en  out  1  apply the round constant to the current slice.
- mem_req  out  1  read request for slice cnt_value.
- mem_wr  out  1  write write_value back to slice cnt_value.
- mem_addr  out  6  slice address; equals cnt_value whenever mem_req or mem_wr is high.
- round_idx  out  ROUND_W  current round, 0..NUM_ROUNDS-1; selects the round constant.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on completion.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, round_idx=0, all outputs 0. rst overrides every state, including mid-operation; no partial write is issued after reset.
- Outputs are Moore (decoded from state) except mem_addr, which is combinational from cnt_value.
- IDLE: busy=0. start=1 -> INIT.
- INIT (1 cycle): cnt_rst_64=1, round_idx<=0 -> READ.
- READ: mem_req=1.
  - Stays in READ until mem_ack=1; then -> LOAD.
  - mem_req is held high, with a stable address, while waiting.
- LOAD (1 cycle): inreg_en=1 -> XOR.
- XOR (1 cycle): xor_en=1 -> WRITE.
- WRITE (1 cycle): mem_wr=1, cnt_en_64=1 (counter wraps 63->0).
  - cnt_co_64=0 -> READ.
  - cnt_co_64=1 and round_idx < NUM_ROUNDS-1 -> round_idx<=round_idx+1 -> READ.
  - cnt_co_64=1 and round_idx = NUM_ROUNDS-1 -> DONE.
- DONE (1 cycle): done=1, busy=1 -> IDLE. round_idx holds its final value until the next INIT.
- start is ignored while busy, including a start asserted in the DONE cycle. A start held high through IDLE launches one new operation per return to IDLE.
- At most one of inreg_en, xor_en, mem_req, mem_wr is high in any cycle. cnt_en_64 is high only in WRITE. cnt_rst_64 is high only in INIT.
- Latency with mem_ack tied high:
  - 4 cycles per slice, 256 cycles per round.
  - start sampled at edge 0 -> done high in the cycle after edge 1+256*NUM_ROUNDS.
  - NUM_ROUNDS=24: done follows edge 6145.
- Each mem_ack-low cycle in READ adds exactly one cycle to total latency.
- cnt_value is trusted. The FSM does not count slices itself; termination depends on cnt_co_64 only.

Test Plan:
- Reset/idle:
  - rst=1 for 2 cycles, then start=0 for 10 cycles -> all outputs 0, busy=0.
- Single round (NUM_ROUNDS=1, mem_ack=1):
  - start pulse at edge 0 -> cnt_rst_64 in cycle 1.
  - Pattern mem_req, inreg_en, xor_en, mem_wr repeats 64 times, with mem_addr=0..63 in order.
  - done pulse after edge 257; exactly 64 mem_wr and 64 cnt_en_64 pulses.
- Multi-round (NUM_ROUNDS=24):
  - round_idx steps 0->23, each value held for exactly 256 cycles.
  - 1536 writes total; done after edge 6145; round_idx=23 in DONE.
- Memory stall:
  - mem_ack low for 3 cycles on slice 5 of round 0 -> READ held 4 cycles, with mem_req=1 and mem_addr=5 throughout.
  - Total latency +3 cycles; no inreg_en before mem_ack.
- Start while busy:
  - start pulses at slice 10 and in the DONE cycle -> ignored; exactly one done pulse.
  - A start 1 cycle after return to IDLE launches a new operation.
- Reset mid-operation:
  - rst=1 during XOR of slice 30, round 2 -> next cycle IDLE, round_idx=0, no mem_wr.
  - Then start -> full run from slice 0, round 0.
